// File: rtl/soc_gpio_mem_read_sequencer.sv
// Single-word external memory reader that masters the 20-bit memory-read PIO.
// Runs the address write, strobe set/poll ack/strobe clear/poll release sequence, then answers once.
module soc_gpio_mem_read_sequencer #(
  parameter int SETUP_CYCLES  = 2,
  parameter int TIMEOUT_POLLS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  gpio_address,
  output logic        gpio_chipselect,
  output logic        gpio_write_n,
  output logic [31:0] gpio_writedata,
  input  logic [31:0] gpio_readdata,
  output logic [3:0]  dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // rsp_valid is a single-cycle pulse, and rsp_data/rsp_err hold until the next pulse.

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WR_ADDR = 4'd1;
  localparam logic [3:0] ST_SETUP   = 4'd2;
  localparam logic [3:0] ST_SET_STB = 4'd3;
  localparam logic [3:0] ST_ACK_RD  = 4'd4;
  localparam logic [3:0] ST_ACK_CHK = 4'd5;
  localparam logic [3:0] ST_CLR_STB = 4'd6;
  localparam logic [3:0] ST_REL_RD  = 4'd7;
  localparam logic [3:0] ST_REL_CHK = 4'd8;
  localparam logic [3:0] ST_RESP    = 4'd9;

  localparam logic [7:0]  LP_TIMEOUT    = 8'(TIMEOUT_POLLS);
  localparam logic [7:0]  LP_SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [31:0] LP_STROBE     = 32'h0001_0000;

  logic [3:0]  r_state;
  logic [15:0] r_addr;
  logic [7:0]  r_poll_cnt;
  logic [7:0]  r_setup_cnt;
  logic [15:0] r_cap_data;
  logic        r_cap_err;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;

  logic [7:0]  w_poll_next;
  logic        w_poll_timeout;
  logic        w_ack;
  logic        w_unused;

  assign w_poll_next    = r_poll_cnt + 8'd1;
  assign w_poll_timeout = (w_poll_next == LP_TIMEOUT);
  assign w_ack          = gpio_readdata[16];
  assign w_unused       = &{1'b0, gpio_readdata[31:17]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= 16'h0;
      r_poll_cnt  <= 8'h0;
      r_setup_cnt <= 8'h0;
      r_cap_data  <= 16'h0;
      r_cap_err   <= 1'b0;
      r_rsp_data  <= 16'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_state <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          r_setup_cnt <= 8'h0;
          r_state     <= (SETUP_CYCLES == 0) ? ST_SET_STB : ST_SETUP;
        end
        ST_SETUP: begin
          if (r_setup_cnt == LP_SETUP_LAST) r_state <= ST_SET_STB;
          else r_setup_cnt <= r_setup_cnt + 8'd1;
        end
        ST_SET_STB: begin
          r_poll_cnt <= 8'h0;
          r_state    <= ST_ACK_RD;
        end
        ST_ACK_RD: r_state <= ST_ACK_CHK;
        ST_ACK_CHK: begin
          if (w_ack) begin
            r_cap_data <= gpio_readdata[15:0];
            r_cap_err  <= 1'b0;
            r_state    <= ST_CLR_STB;
          end else begin
            r_poll_cnt <= w_poll_next;
            if (w_poll_timeout) begin
              r_cap_data <= 16'h0;
              r_cap_err  <= 1'b1;
              r_state    <= ST_CLR_STB;
            end else begin
              r_state <= ST_ACK_RD;
            end
          end
        end
        // The strobe is always cleared, even after an ack timeout, so the memory side is released.
        ST_CLR_STB: begin
          r_poll_cnt <= 8'h0;
          r_state    <= ST_REL_RD;
        end
        ST_REL_RD: r_state <= ST_REL_CHK;
        ST_REL_CHK: begin
          if (!w_ack) begin
            r_rsp_data <= r_cap_data;
            r_rsp_err  <= r_cap_err;
            r_state    <= ST_RESP;
          end else begin
            r_poll_cnt <= w_poll_next;
            if (w_poll_timeout) begin
              r_rsp_data <= r_cap_data;
              r_rsp_err  <= 1'b1;
              r_state    <= ST_RESP;
            end else begin
              r_state <= ST_REL_RD;
            end
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs are a pure decode of the registered state; idle value everywhere else.
  always_comb begin
    gpio_chipselect = 1'b0;
    gpio_write_n    = 1'b1;
    gpio_address    = 3'd0;
    gpio_writedata  = 32'h0;
    case (r_state)
      ST_WR_ADDR: begin
        gpio_chipselect = 1'b1;
        gpio_write_n    = 1'b0;
        gpio_writedata  = {16'h0, r_addr};
      end
      ST_SET_STB: begin
        gpio_chipselect = 1'b1;
        gpio_write_n    = 1'b0;
        gpio_address    = 3'd4;
        gpio_writedata  = LP_STROBE;
      end
      ST_CLR_STB: begin
        gpio_chipselect = 1'b1;
        gpio_write_n    = 1'b0;
        gpio_address    = 3'd5;
        gpio_writedata  = LP_STROBE;
      end
      ST_ACK_RD, ST_REL_RD: gpio_chipselect = 1'b1;
      default: ;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_soc_gpio_mem_read_sequencer.sv
// Bench for soc_gpio_mem_read_sequencer: PIO + memory model, transaction-level
// expectation model with a per-cycle compare process, plus literal checks.
module tb_soc_gpio_mem_read_sequencer;

  localparam int S = 2;
  localparam int T = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic [2:0]  gpio_address;
  logic        gpio_chipselect, gpio_write_n;
  logic [31:0] gpio_writedata, gpio_readdata;
  logic [3:0]  dbg_state;

  soc_gpio_mem_read_sequencer #(.SETUP_CYCLES(S), .TIMEOUT_POLLS(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .gpio_address(gpio_address), .gpio_chipselect(gpio_chipselect),
    .gpio_write_n(gpio_write_n), .gpio_writedata(gpio_writedata),
    .gpio_readdata(gpio_readdata), .dbg_state(dbg_state)
  );

  // ---------------- PIO + external memory model ----------------
  int mem_mode = 0;   // 0: ack after ack_delay failed checks, 1: never ack, 2: ack stuck high
  int ack_delay = 0;
  logic [19:0] pio_out;
  logic [31:0] pio_rd;
  logic [7:0]  sreads;
  logic        stuck_seen;
  logic        ack_in;
  logic [31:0] in_port;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0123) ? 16'hBEEF : ((a ^ 16'h5A5A) + 16'h0101);
  endfunction

  always_comb begin
    ack_in = 1'b0;
    case (mem_mode)
      0: ack_in = pio_out[16] && (int'(sreads) >= ack_delay);
      1: ack_in = 1'b0;
      default: ack_in = pio_out[16] || stuck_seen;
    endcase
    in_port = {15'h0, ack_in, mem_word(pio_out[15:0])};
  end
  assign gpio_readdata = pio_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_out <= 20'h0; pio_rd <= 32'h0; sreads <= 8'h0; stuck_seen <= 1'b0;
    end else begin
      pio_rd <= (gpio_chipselect && gpio_address == 3'd0) ? in_port : 32'h0;
      if (gpio_chipselect && !gpio_write_n) begin
        case (gpio_address)
          3'd0: pio_out <= gpio_writedata[19:0];
          3'd4: pio_out <= pio_out | gpio_writedata[19:0];
          3'd5: pio_out <= pio_out & ~gpio_writedata[19:0];
          default: ;
        endcase
      end
      if (!pio_out[16]) sreads <= 8'h0;
      else if (gpio_chipselect && gpio_write_n && gpio_address == 3'd0) sreads <= sreads + 8'd1;
      if (mem_mode != 2) stuck_seen <= 1'b0;
      else if (pio_out[16]) stuck_seen <= 1'b1;
    end
  end

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit in_reset = 1'b1;
  bit have_txn = 1'b0;
  int c0 = 0, prev_c0 = 0, rsp_cyc = 0;
  int exp_ack_rd = 0, exp_rel_rd = 0, ack_rd_cnt = 0, rel_rd_cnt = 0;
  int obs_lat = 0, obs_ack_rd = 0, obs_rel_rd = 0, n_rsp = 0;
  logic [15:0] obs_data = 16'h0;
  logic        obs_err = 1'b0;
  logic [15:0] last_data = 16'h0;
  logic        last_err = 1'b0;
  logic [31:0] last_wr0 = 32'h0;
  logic [34:0] exp_q[$];
  logic [16:0] exp_rsp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level expectation: number of checks per phase, data and error from the memory mode.
  task automatic model_accept(input logic [15:0] a);
    int na, nr;
    logic ok_a, ok_r;
    ok_a = 1'b1; ok_r = 1'b1; na = 1; nr = 1;
    if (mem_mode == 0) begin
      if (ack_delay < T) na = ack_delay + 1;
      else begin na = T; ok_a = 1'b0; end
    end else if (mem_mode == 1) begin
      na = T; ok_a = 1'b0;
    end else begin
      nr = T; ok_r = 1'b0;
    end
    exp_q.push_back({3'd0, 16'h0, a});
    exp_q.push_back({3'd4, 32'h0001_0000});
    exp_q.push_back({3'd5, 32'h0001_0000});
    exp_rsp_q.push_back({!(ok_a && ok_r), ok_a ? mem_word(a) : 16'h0});
    prev_c0 = c0;
    c0 = cyc;
    rsp_cyc = cyc + S + 4 + 2 * na + 2 * nr;
    exp_ack_rd = na; exp_rel_rd = nr;
    ack_rd_cnt = 0; rel_rd_cnt = 0;
    have_txn = 1'b1;
  endtask

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!in_reset) begin
      check("req_ready", {31'h0, req_ready}, {31'h0, !(have_txn && cyc > c0 && cyc <= rsp_cyc)});
      check("rsp_valid", {31'h0, rsp_valid}, {31'h0, (have_txn && cyc == rsp_cyc)});
      if (gpio_chipselect && !gpio_write_n) begin
        if (gpio_address == 3'd0) last_wr0 = gpio_writedata;
        if (exp_q.size() == 0) check("unexpected_write", {29'h0, gpio_address}, 32'hFFFF_FFFF);
        else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {29'h0, gpio_address}, {29'h0, e[34:32]});
          check("wr_data", gpio_writedata, e[31:0]);
        end
      end else if (gpio_chipselect) begin
        check("rd_addr", {29'h0, gpio_address}, 32'h0);
        if (pio_out[16]) ack_rd_cnt++;
        else rel_rd_cnt++;
      end else begin
        check("idle_bus", {gpio_write_n, gpio_address, gpio_writedata[27:0]}, 32'h8000_0000);
      end
      if (have_txn && cyc == rsp_cyc) begin
        {last_err, last_data} = exp_rsp_q.pop_front();
        check("ack_reads", ack_rd_cnt, exp_ack_rd);
        check("rel_reads", rel_rd_cnt, exp_rel_rd);
        check("writes_done", exp_q.size(), 0);
        obs_lat = cyc - c0; obs_data = rsp_data; obs_err = rsp_err;
        obs_ack_rd = ack_rd_cnt; obs_rel_rd = rel_rd_cnt;
        n_rsp++;
      end
      check("rsp_data", {16'h0, rsp_data}, {16'h0, last_data});
      check("rsp_err", {31'h0, rsp_err}, {31'h0, last_err});
      if (req_valid && req_ready) model_accept(req_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check(name, 32'h0, 32'h1);
  endtask

  task automatic do_req(input logic [15:0] a);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a;
    wait_ready("accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (!(have_txn && cyc <= rsp_cyc)) begin ok = 1'b1; break; end
    end
    if (!ok) check("response_timeout", 32'h0, 32'h1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    check("rst_cs", {31'h0, gpio_chipselect}, 32'h0);
    check("rst_state", {28'h0, dbg_state}, 32'h0);
    reset_n = 1'b1; in_reset = 1'b0;
    @(negedge clk); #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // Fast read
    mem_mode = 0; ack_delay = 0;
    do_req(16'h0123); wait_done();
    check("fast_lat", obs_lat, 10);
    check("fast_data", {16'h0, obs_data}, 32'h0000_BEEF);
    check("fast_err", {31'h0, obs_err}, 32'h0);
    check("fast_wr0", last_wr0, 32'h0000_0123);
    check("fast_pio_out", {12'h0, pio_out}, 32'h0000_0123);

    // Slow ack: three failed checks
    ack_delay = 3;
    do_req(16'h0456); wait_done();
    check("slow_lat", obs_lat, S + 14);
    check("slow_data", {16'h0, obs_data}, {16'h0, mem_word(16'h0456)});
    check("slow_err", {31'h0, obs_err}, 32'h0);

    // Ack never asserted
    mem_mode = 1;
    do_req(16'h0777); wait_done();
    check("never_lat", obs_lat, 40);
    check("never_ack_reads", obs_ack_rd, 16);
    check("never_data", {16'h0, obs_data}, 32'h0);
    check("never_err", {31'h0, obs_err}, 32'h1);
    check("never_strobe", {31'h0, pio_out[16]}, 32'h0);

    // Ack stuck high after the strobe clear
    mem_mode = 2;
    do_req(16'h0123); wait_done();
    check("stuck_lat", obs_lat, 40);
    check("stuck_rel_reads", obs_rel_rd, 16);
    check("stuck_data", {16'h0, obs_data}, 32'h0000_BEEF);
    check("stuck_err", {31'h0, obs_err}, 32'h1);

    // Back-to-back with req_valid held high
    mem_mode = 0; ack_delay = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 16'h0A0A;
    wait_ready("b2b_first");
    @(posedge clk); #1;
    req_addr = 16'h0B0B;
    wait_ready("b2b_second");
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();
    check("b2b_gap", c0 - prev_c0, S + 9);
    check("b2b_data", {16'h0, obs_data}, {16'h0, mem_word(16'h0B0B)});
    check("b2b_rsp_count", n_rsp, 6);

    // Reset asserted during ACK_RD
    mem_mode = 1;
    do_req(16'h0321);
    repeat (4) @(posedge clk);
    #1;
    in_reset = 1'b1; reset_n = 1'b0;
    #2;
    check("midrst_cs", {31'h0, gpio_chipselect}, 32'h0);
    check("midrst_write_n", {31'h0, gpio_write_n}, 32'h1);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_pio_out", {12'h0, pio_out}, 32'h0);
    have_txn = 1'b0; exp_q.delete(); exp_rsp_q.delete();
    last_data = 16'h0; last_err = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; in_reset = 1'b0;
    @(negedge clk); #1;
    check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (5) @(negedge clk);
    check("midrst_no_rsp", n_rsp, 6);

    mem_mode = 0;
    do_req(16'h0123); wait_done();
    check("post_rst_lat", obs_lat, 10);
    check("post_rst_data", {16'h0, obs_data}, 32'h0000_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
